cmd_tx: RTL and testbench
=========================

CMD_TX -- requirements
Module: cmd_tx

Interface
REQ-001 SHALL have parameter MAIN_CLK_FREQ, default 120000000, meaning clk frequency in Hz.
REQ-002 SHALL have parameter UART_BAUD, default 115200, meaning serial bit rate.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, meaning transmit buffer entries (power of two, 2..256).
REQ-004 SHALL have port clk  input  1  meaning the single clock; all logic is rising-edge clk.
REQ-005 SHALL have port rst  input  1  meaning asynchronous, active-high reset.
REQ-006 SHALL have port data_en  input  1  meaning byte write strobe, one byte per high cycle.
REQ-007 SHALL have port data  input  8  meaning byte to transmit, sampled when data_en=1.
REQ-008 SHALL have port data_ready  output  1  meaning buffer can accept a byte this cycle (not full).
REQ-009 SHALL have port overflow_flag  output  1  meaning sticky: a write was dropped because the buffer was full.
REQ-010 SHALL have port tx_busy  output  1  meaning a frame is on the line or the buffer is non-empty.
REQ-011 SHALL have port uart_tx  output  1  meaning serial line, idle high.

Function
REQ-012 SHALL use CLKS_PER_BIT = MAIN_CLK_FREQ / UART_BAUD (integer division); every line bit lasts exactly CLKS_PER_BIT clk cycles.
REQ-013 SHALL write data into the buffer on a cycle with data_en=1 and data_ready=1; data_ready SHALL equal NOT full, from registered occupancy count.
REQ-014 SHALL drop a write with data_en=1 and data_ready=0, leave buffer contents unchanged and set overflow_flag=1 from the next cycle until reset.
REQ-015 SHALL, on simultaneous write and pop, update occupancy by net zero and lose no byte.
REQ-016 SHALL handle pointer wrap-around modulo FIFO_DEPTH; full at count=FIFO_DEPTH, empty at count=0.
REQ-017 SHALL implement serializer states IDLE, START, DATA, [PARITY], STOP.
REQ-018 SHALL, in IDLE with buffer non-empty, pop one byte into a shift register and enter START the next cycle; IDLE with buffer empty holds uart_tx=1.
REQ-019 SHALL drive START low, then DATA 8 bits LSB first, then STOP high, each for CLKS_PER_BIT cycles, with a bit counter 0..7 in DATA.
REQ-020 SHALL return from STOP to IDLE, giving back-to-back frame period 10*CLKS_PER_BIT+1 cycles (11*CLKS_PER_BIT+1 with parity).
REQ-021 SHALL, with serializer in IDLE and buffer empty, drive uart_tx low exactly 2 cycles after the data_en cycle.
REQ-022 SHALL drive uart_tx from a register (glitch-free).
REQ-023 SHALL assert tx_busy when state is not IDLE or buffer is non-empty.

Reset
REQ-024 SHALL, on rst=1 (asynchronous, including mid-frame), immediately set uart_tx=1, state=IDLE, occupancy=0, pointers=0, baud and bit counters=0, overflow_flag=0, tx_busy=0, data_ready=1; the aborted frame is not resumed.
REQ-025 SHALL ignore data_en while rst=1.

Configuration
REQ-026 SHALL, with macro CMD_TX_PARITY_EN defined, insert a PARITY state between DATA and STOP transmitting even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
REQ-027 SHALL, without CMD_TX_PARITY_EN, contain no parity logic and send 8N1 frames.

Verification (MAIN_CLK_FREQ=1000000, UART_BAUD=100000, CLKS_PER_BIT=10)
REQ-028 SHALL cover: idle, write 0xA5 at cycle t -> uart_tx low at t+2 for 10 cycles, bits 1,0,1,0,0,1,0,1 at 10 cycles each, high 10 cycles, tx_busy falls after stop.
REQ-029 SHALL cover: 3 consecutive writes 0x00,0xFF,0x55 -> three frames, start edges 101 cycles apart, order preserved.
REQ-030 SHALL cover: 17 writes while the first frame is in flight (depth 16) -> data_ready low when full, 17th write dropped, overflow_flag=1, exactly 17 frames of which the dropped byte is absent... (first byte popped frees one slot; bench checks byte count equals accepted writes).
REQ-031 SHALL cover: rst pulse mid-DATA of 0x3C -> uart_tx=1 during the same cycle, buffer empty, no partial frame resumes, next write 0x81 transmits correctly.
REQ-032 SHALL cover: with CMD_TX_PARITY_EN, write 0x07 -> parity bit 1, 0x03 -> parity bit 0, frame period 111 cycles.
REQ-033 SHALL cover: write with buffer full and simultaneous pop -> write rejected (data_ready=0 that cycle), count drops to FIFO_DEPTH-1.

Source files
------------

// File: rtl/cmd_tx.sv
// Buffered UART transmitter: byte FIFO feeding an 8N1 serializer.
// Define CMD_TX_PARITY_EN to append an even-parity bit (8E1 frames).
module cmd_tx #(
    parameter int MAIN_CLK_FREQ = 120000000,
    parameter int UART_BAUD     = 115200,
    parameter int FIFO_DEPTH    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       data_en,
    input  logic [7:0] data,
    output logic       data_ready,
    output logic       overflow_flag,
    output logic       tx_busy,
    output logic       uart_tx,
    output logic [2:0] state_dbg_o
);

    localparam int CLKS_PER_BIT = MAIN_CLK_FREQ / UART_BAUD;
    localparam int BAUD_W       = $clog2(CLKS_PER_BIT + 1);
    localparam int PTR_W        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W        = PTR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd4
`ifdef CMD_TX_PARITY_EN
        , S_PARITY = 3'd3
`endif
    } state_t;

    state_t            state_q;
    logic [BAUD_W-1:0] baud_q;
    logic [2:0]        bit_q;
    logic [7:0]        shreg_q;
    logic              uart_tx_q;
    logic              ovf_q;
`ifdef CMD_TX_PARITY_EN
    logic              parity_q;
`endif

    logic [7:0]        mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              wr_en, pop, baud_last;

    assign data_ready    = (count_q != CNT_W'(FIFO_DEPTH));
    assign wr_en         = data_en && data_ready && !rst;
    assign pop           = (state_q == S_IDLE) && (count_q != '0);
    assign baud_last     = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
    assign uart_tx       = uart_tx_q;
    assign overflow_flag = ovf_q;
    assign tx_busy       = (state_q != S_IDLE) || (count_q != '0);
    assign state_dbg_o   = state_q;

    // A write and a pop in the same cycle leave occupancy unchanged.
    always_comb begin
        count_d = count_q;
        case ({wr_en, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
            if (data_en && !data_ready) ovf_q <= 1'b1;
        end
    end

    // Serializer: each line bit is held for CLKS_PER_BIT cycles by baud_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            baud_q    <= '0;
            bit_q     <= '0;
            shreg_q   <= '0;
            uart_tx_q <= 1'b1;
`ifdef CMD_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    uart_tx_q <= 1'b1;
                    baud_q    <= '0;
                    if (pop) begin
                        shreg_q   <= mem_q[rd_ptr_q];
`ifdef CMD_TX_PARITY_EN
                        parity_q  <= ^mem_q[rd_ptr_q];
`endif
                        uart_tx_q <= 1'b0;
                        state_q   <= S_START;
                    end
                end
                S_START: begin
                    if (baud_last) begin
                        baud_q    <= '0;
                        bit_q     <= '0;
                        uart_tx_q <= shreg_q[0];
                        shreg_q   <= shreg_q >> 1;
                        state_q   <= S_DATA;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (baud_last) begin
                        baud_q <= '0;
                        if (bit_q == 3'd7) begin
`ifdef CMD_TX_PARITY_EN
                            uart_tx_q <= parity_q;
                            state_q   <= S_PARITY;
`else
                            uart_tx_q <= 1'b1;
                            state_q   <= S_STOP;
`endif
                        end else begin
                            bit_q     <= bit_q + 1'b1;
                            uart_tx_q <= shreg_q[0];
                            shreg_q   <= shreg_q >> 1;
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
`ifdef CMD_TX_PARITY_EN
                S_PARITY: begin
                    if (baud_last) begin
                        baud_q    <= '0;
                        uart_tx_q <= 1'b1;
                        state_q   <= S_STOP;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (baud_last) begin
                        baud_q  <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                default: begin
                    uart_tx_q <= 1'b1;
                    baud_q    <= '0;
                    state_q   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_tx.sv
// Directed bench for cmd_tx at 10 clocks per bit; every line cycle of each frame is checked.
module tb_cmd_tx;

    localparam int CPB = 10;
`ifdef CMD_TX_PARITY_EN
    localparam int NBITS = 11;
    localparam bit PAR   = 1'b1;
`else
    localparam int NBITS = 10;
    localparam bit PAR   = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       data_en;
    logic [7:0] data;
    logic       data_ready, overflow_flag, tx_busy, uart_tx;
    logic [2:0] state_dbg;

    int vec_cnt = 0;
    int err_cnt = 0;

    cmd_tx #(
        .MAIN_CLK_FREQ(1000000),
        .UART_BAUD    (100000),
        .FIFO_DEPTH   (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .data_en      (data_en),
        .data         (data),
        .data_ready   (data_ready),
        .overflow_flag(overflow_flag),
        .tx_busy      (tx_busy),
        .uart_tx      (uart_tx),
        .state_dbg_o  (state_dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic write_byte(input logic [7:0] b);
        data_en = 1'b1;
        data    = b;
        tick();
        data_en = 1'b0;
    endtask

    // Entry: current sample is frame cycle 'skip'; exit: first cycle after the stop bit.
    task automatic expect_frame(input logic [7:0] b, input int skip);
        for (int j = skip; j < NBITS * CPB; j++) begin
            int  i;
            logic e;
            i = j / CPB;
            if (i == 0)                  e = 1'b0;
            else if (i <= 8)             e = b[i-1];
            else if (PAR && i == 9)      e = ^b;
            else                         e = 1'b1;
            chk($sformatf("frame_%h_bit%0d_cyc%0d", b, i, j % CPB), {7'd0, uart_tx}, {7'd0, e});
            tick();
        end
    endtask

    initial begin
        rst = 1'b1; data_en = 1'b0; data = 8'h00;
        tick();
        data_en = 1'b1; data = 8'h99;
        tick();
        chk("rst_uart_tx", {7'd0, uart_tx}, 8'd1);
        chk("rst_data_ready", {7'd0, data_ready}, 8'd1);
        chk("rst_tx_busy", {7'd0, tx_busy}, 8'd0);
        chk("rst_overflow", {7'd0, overflow_flag}, 8'd0);
        chk("rst_state", {5'd0, state_dbg}, 8'd0);
        data_en = 1'b0;
        rst = 1'b0;
        tick();
        tick();
        chk("rst_write_ignored_busy", {7'd0, tx_busy}, 8'd0);
        chk("rst_write_ignored_tx", {7'd0, uart_tx}, 8'd1);

        // Single byte 0xA5: start bit two cycles after the write cycle.
        write_byte(8'hA5);
        chk("a5_t1_tx_idle", {7'd0, uart_tx}, 8'd1);
        chk("a5_t1_busy", {7'd0, tx_busy}, 8'd1);
        tick();
        expect_frame(8'hA5, 0);
        chk("a5_done_busy", {7'd0, tx_busy}, 8'd0);
        chk("a5_done_state", {5'd0, state_dbg}, 8'd0);

        // Back-to-back 0x00, 0xFF, 0x55.
        write_byte(8'h00);
        data_en = 1'b1; data = 8'hFF;
        tick();
        data = 8'h55;
        tick();
        data_en = 1'b0;
        expect_frame(8'h00, 1);
        chk("b2b_gap1_tx", {7'd0, uart_tx}, 8'd1);
        chk("b2b_gap1_busy", {7'd0, tx_busy}, 8'd1);
        tick();
        expect_frame(8'hFF, 0);
        chk("b2b_gap2_tx", {7'd0, uart_tx}, 8'd1);
        tick();
        expect_frame(8'h55, 0);
        chk("b2b_done_busy", {7'd0, tx_busy}, 8'd0);

        // Fill during a frame: 16 accepted, 17th dropped.
        write_byte(8'h40);
        tick();
        for (int k = 1; k <= 17; k++) begin
            chk($sformatf("fill_ready_%0d", k), {7'd0, data_ready}, (k <= 16) ? 8'd1 : 8'd0);
            chk($sformatf("fill_ovf_%0d", k), {7'd0, overflow_flag}, 8'd0);
            data_en = 1'b1;
            data    = 8'h40 + 8'(k);
            tick();
        end
        data_en = 1'b0;
        chk("full_ovf_set", {7'd0, overflow_flag}, 8'd1);
        chk("full_not_ready", {7'd0, data_ready}, 8'd0);
        expect_frame(8'h40, 17);
        // Write while full on the pop cycle: rejected, occupancy drops to 15.
        chk("pop_full_ready", {7'd0, data_ready}, 8'd0);
        chk("pop_full_tx", {7'd0, uart_tx}, 8'd1);
        data_en = 1'b1; data = 8'hEE;
        tick();
        data_en = 1'b0;
        chk("pop_full_ready_after", {7'd0, data_ready}, 8'd1);
        expect_frame(8'h41, 0);
        for (int k = 2; k <= 16; k++) begin
            chk($sformatf("fill_gap_%0d", k), {7'd0, uart_tx}, 8'd1);
            tick();
            expect_frame(8'h40 + 8'(k), 0);
        end
        chk("fill_done_busy", {7'd0, tx_busy}, 8'd0);
        for (int k = 0; k < 30; k++) begin
            chk("fill_no_extra_frame", {7'd0, uart_tx}, 8'd1);
            tick();
        end
        chk("ovf_sticky", {7'd0, overflow_flag}, 8'd1);

        // Asynchronous reset in the middle of 0x3C.
        write_byte(8'h3C);
        tick();
        repeat (25) tick();
        chk("abort_mid_data_low", {7'd0, uart_tx}, 8'd0);
        #2 rst = 1'b1;
        #1;
        chk("abort_tx_high", {7'd0, uart_tx}, 8'd1);
        chk("abort_busy", {7'd0, tx_busy}, 8'd0);
        chk("abort_ready", {7'd0, data_ready}, 8'd1);
        chk("abort_ovf_clr", {7'd0, overflow_flag}, 8'd0);
        chk("abort_state", {5'd0, state_dbg}, 8'd0);
        data_en = 1'b1; data = 8'h77;
        tick();
        tick();
        data_en = 1'b0;
        rst = 1'b0;
        for (int k = 0; k < 30; k++) begin
            chk("abort_no_resume", {7'd0, uart_tx}, 8'd1);
            tick();
        end
        chk("abort_idle_busy", {7'd0, tx_busy}, 8'd0);
        write_byte(8'h81);
        tick();
        expect_frame(8'h81, 0);
        chk("after_abort_busy", {7'd0, tx_busy}, 8'd0);

        // 0x07 and 0x03 back to back (parity 1 and 0 when enabled).
        write_byte(8'h07);
        data_en = 1'b1; data = 8'h03;
        tick();
        data_en = 1'b0;
        expect_frame(8'h07, 0);
        chk("par_gap_tx", {7'd0, uart_tx}, 8'd1);
        tick();
        expect_frame(8'h03, 0);
        chk("par_done_busy", {7'd0, tx_busy}, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
